dmem_arbiter: RTL

Two-port arbiter that shares the single-ported 512 x 19-bit data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader). It grants at most one access per cycle with round-robin fairness. It drives the memory's address, write-data and read/write strobes, tracks the one-cycle read latency, and returns read data to the port that issued the read. It sits between the CPU datapath and the data memory, and is the only master of the memory's command inputs.

---
 rtl/dmem_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between two requesters.
//   Port 0 (CPU load/store) and port 1 (debug/DMA loader) request with
//   mX_req/mX_we/mX_addr/mX_wdata and are accepted by mX_gnt. At most one
//   access is granted per cycle, with round-robin arbitration on conflicts.
//   Read data returns one cycle after the grant on mX_rvalid/mX_rdata.
//   mem_addr/mem_write_data/mem_write/mem_read drive the memory;
//   mem_read_data is the memory's registered read output.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e last_gnt_q, last_gnt_d;
  logic  m0_rvalid_q, m0_rvalid_d;
  logic  m1_rvalid_q, m1_rvalid_d;
  logic  gnt0, gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        // conflict: the port that did not win last time goes first
        gnt0 = (last_gnt_q == PORT1);
        gnt1 = (last_gnt_q == PORT0);
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end

    // port 0 inputs are the default path; strobes are low when idle
    mem_addr       = gnt1 ? m1_addr  : m0_addr;
    mem_write_data = gnt1 ? m1_wdata : m0_wdata;
    mem_write      = (gnt0 & m0_we)  | (gnt1 & m1_we);
    mem_read       = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);

    last_gnt_d = last_gnt_q;
    if (gnt1) begin
      last_gnt_d = PORT1;
    end else if (gnt0) begin
      last_gnt_d = PORT0;
    end

    m0_rvalid_d = gnt0 & ~m0_we;
    m1_rvalid_d = gnt1 & ~m1_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= PORT1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  // a read issued just before reset must not surface while reset is held
  assign m0_rvalid = m0_rvalid_q & ~rst;
  assign m1_rvalid = m1_rvalid_q & ~rst;
  assign m0_rdata  = mem_read_data;
  assign m1_rdata  = mem_read_data;

endmodule
